// File: rtl/sfp_row_gen.sv
// sfp_row_gen: one COL-wide special-function row. Each acc computes the row's
// absolute sum and queues it in an internal and an external FIFO; each div
// divides |x| of every lane by the combined denominator
// (int_head>>SUM_SHIFT)+(sum_in>>SUM_SHIFT) using a BW_PSUM-step restoring
// divider, optionally re-applying the input sign.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   acc, div            push row sum / request divide of the row on sfp_in
//   sign_mode           0: |x|/d, 1: sign(x)*(|x|/d); sampled with div
//   fifo_ext_rd         pop the external sum FIFO
//   sfp_in, sum_in      psum row (lane i at [BW*(i+1)-1:BW*i]), other core's sum
//   sfp_out, out_valid  normalised row, 1-cycle update strobe
//   div_ready           idle with internal FIFO non-empty
//   sum_out             external FIFO head (0 when empty)
//   fifo_full, err      internal FIFO full, sticky error

// Count-based FWFT FIFO; rdata reads 0 while empty.
module sfp_row_gen_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign rdata = empty ? '0 : mem_q[rp_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = wp_q + AW'(do_push);
    rp_d    = rp_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end
endmodule

// One lane: abs value, restoring divider (dividend register doubles as the
// quotient shift register), and sign/saturation on the result.
module sfp_row_gen_lane #(
  parameter int BW_PSUM = 20,
  parameter int SUM_BW  = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               sm,
  input  logic [BW_PSUM-1:0] x_in,
  input  logic [SUM_BW-1:0]  dvs,
  output logic [BW_PSUM-1:0] abs_x,
  output logic [BW_PSUM-1:0] res
);
  logic [BW_PSUM-1:0] dq_q, dq_d, q_mag;
  logic [SUM_BW-1:0]  rem_q, rem_d, rem_sh;
  logic               neg_q, neg_d, ge;

  always_comb begin
    abs_x  = x_in[BW_PSUM-1] ? -x_in : x_in;
    // Remainder stays below dvs, so a set MSB before the shift means the
    // shifted value already exceeds any SUM_BW-bit divisor.
    rem_sh = {rem_q[SUM_BW-2:0], dq_q[BW_PSUM-1]};
    ge     = rem_q[SUM_BW-1] || (rem_sh >= dvs);
    dq_d   = dq_q;
    rem_d  = rem_q;
    neg_d  = neg_q;
    if (load) begin
      dq_d  = abs_x;
      rem_d = '0;
      neg_d = x_in[BW_PSUM-1];
    end else if (step) begin
      rem_d = ge ? (rem_sh - dvs) : rem_sh;
      dq_d  = {dq_q[BW_PSUM-2:0], ge};
    end
    // Only |-2^(BW-1)|/1 reaches the MSB; clamp so the signed result fits.
    q_mag = dq_q;
    if (sm && dq_q[BW_PSUM-1]) q_mag = {1'b0, {(BW_PSUM-1){1'b1}}};
    res = (sm && neg_q) ? -q_mag : q_mag;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dq_q  <= '0;
      rem_q <= '0;
      neg_q <= 1'b0;
    end else begin
      dq_q  <= dq_d;
      rem_q <= rem_d;
      neg_q <= neg_d;
    end
  end
endmodule

module sfp_row_gen #(
  parameter int COL        = 8,
  parameter int BW_PSUM    = 20,
  parameter int SUM_BW     = BW_PSUM + 4,
  parameter int SUM_SHIFT  = 7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   acc,
  input  logic                   div,
  input  logic                   sign_mode,
  input  logic                   fifo_ext_rd,
  input  logic [COL*BW_PSUM-1:0] sfp_in,
  input  logic [SUM_BW-1:0]      sum_in,
  output logic [COL*BW_PSUM-1:0] sfp_out,
  output logic                   out_valid,
  output logic                   div_ready,
  output logic [SUM_BW-1:0]      sum_out,
  output logic                   fifo_full,
  output logic                   err
);
  localparam int CW = $clog2(BW_PSUM + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
  typedef logic [COL-1:0][BW_PSUM-1:0] row_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SUM_BW-1:0] dvs_q, dvs_d, d_raw, row_sum, int_head;
  logic              sm_q, sm_d, out_valid_q, out_valid_d, err_q, err_d;
  row_t              sfp_out_q, sfp_out_d, x_row, abs_row, res_row;
  logic              int_empty, int_full, ext_empty, ext_full;
  logic              accept, load, step;

  assign x_row     = sfp_in;
  assign sfp_out   = sfp_out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign fifo_full = int_full;
  assign div_ready = (state_q == S_IDLE) && !int_empty;

  for (genvar i = 0; i < COL; i++) begin : g_lane
    sfp_row_gen_lane #(.BW_PSUM(BW_PSUM), .SUM_BW(SUM_BW)) u_lane (
      .clk(clk), .reset_n(reset_n), .load(load), .step(step), .sm(sm_q),
      .x_in(x_row[i]), .dvs(dvs_q), .abs_x(abs_row[i]), .res(res_row[i])
    );
  end

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < COL; i++) row_sum = row_sum + SUM_BW'(abs_row[i]);
    d_raw = (int_head >> SUM_SHIFT) + (sum_in >> SUM_SHIFT);
    if (d_raw == '0) d_raw = SUM_BW'(1);
  end

  // Internal push is never blocked by the external FIFO; external push needs
  // room in both so the internal FIFO never lags behind.
  sfp_row_gen_fifo #(.W(SUM_BW), .DEPTH(FIFO_DEPTH)) u_int_fifo (
    .clk(clk), .reset_n(reset_n), .push(acc), .pop(accept),
    .wdata(row_sum), .rdata(int_head), .empty(int_empty), .full(int_full)
  );

  sfp_row_gen_fifo #(.W(SUM_BW), .DEPTH(FIFO_DEPTH)) u_ext_fifo (
    .clk(clk), .reset_n(reset_n), .push(acc && !int_full),
    .pop(fifo_ext_rd && !ext_empty), .wdata(row_sum), .rdata(sum_out),
    .empty(ext_empty), .full(ext_full)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvs_d       = dvs_q;
    sm_d        = sm_q;
    sfp_out_d   = sfp_out_q;
    out_valid_d = 1'b0;
    err_d       = err_q;
    accept      = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    if (acc && (int_full || ext_full)) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (div) begin
          if (!int_empty) begin
            accept  = 1'b1;
            load    = 1'b1;
            dvs_d   = d_raw;
            sm_d    = sign_mode;
            cnt_d   = '0;
            state_d = S_DIV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DIV: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BW_PSUM - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        sfp_out_d   = res_row;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvs_q       <= SUM_BW'(1);
      sm_q        <= 1'b0;
      sfp_out_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvs_q       <= dvs_d;
      sm_q        <= sm_d;
      sfp_out_q   <= sfp_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_sfp_row_gen.sv
// Scoreboard bench for sfp_row_gen: expected rows are queued when a div is
// issued and popped by an independent negedge monitor on every out_valid.
module tb_sfp_row_gen;
  localparam int COL = 8, BW = 20, SUM_BW = 24;
  typedef logic [COL-1:0][BW-1:0] row_t;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic              acc = 1'b0, div = 1'b0, sign_mode = 1'b0, fifo_ext_rd = 1'b0;
  row_t              sfp_in_r = '0;
  logic [SUM_BW-1:0] sum_in = '0;
  logic [COL*BW-1:0] sfp_out;
  logic              out_valid, div_ready, fifo_full, err;
  logic [SUM_BW-1:0] sum_out;

  sfp_row_gen #(.COL(COL), .BW_PSUM(BW), .SUM_BW(SUM_BW), .SUM_SHIFT(7), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .acc(acc), .div(div), .sign_mode(sign_mode),
    .fifo_ext_rd(fifo_ext_rd), .sfp_in(sfp_in_r), .sum_in(sum_in), .sfp_out(sfp_out),
    .out_valid(out_valid), .div_ready(div_ready), .sum_out(sum_out),
    .fifo_full(fifo_full), .err(err)
  );

  always #5 clk = ~clk;

  int   ntests = 0, nfail = 0;
  row_t exp_q[$];
  row_t mon_e;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid === 1'b1) begin
      ntests++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_out_valid: got sfp_out=%h, required no output", sfp_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (sfp_out !== mon_e) begin
          nfail++;
          $display("FAIL row_result: got %h, required %h", sfp_out, mon_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input row_t act, input row_t exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t fill(input logic [BW-1:0] v);
    row_t r;
    for (int i = 0; i < COL; i++) r[i] = v;
    return r;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; acc = 1'b0; div = 1'b0; fifo_ext_rd = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic do_acc(input row_t r);
    sfp_in_r = r; acc = 1'b1;
    tick();
    acc = 1'b0;
  endtask

  task automatic pop_ext();
    fifo_ext_rd = 1'b1;
    tick();
    fifo_ext_rd = 1'b0;
  endtask

  // Issue one accepted div; the result itself is checked by the monitor.
  task automatic do_div(input row_t r, input logic [SUM_BW-1:0] s, input logic sm,
                        input row_t e, input logic with_acc, input logic poke);
    int n;
    sfp_in_r = r; sum_in = s; sign_mode = sm; div = 1'b1; acc = with_acc;
    exp_q.push_back(e);
    tick();
    div = 1'b0; acc = 1'b0;
    chk("busy_div_ready", div_ready, 0);
    n = 0;
    if (poke) begin
      div = 1'b1;
      tick();
      div = 1'b0;
      n = 1;
      chk("busy_div_no_err", err, 0);
    end
    while (n < 40 && out_valid !== 1'b1) begin
      tick();
      n++;
    end
    chk("latency", n, 21);
    tick();
    chk("valid_pulse", out_valid, 0);
    chk_row("sfp_out_hold", sfp_out, e);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    row_t r3, e3a, r4, e4a, e4b, r100;
    int   bad;

    do_reset();
    chk_row("reset_sfp_out", sfp_out, '0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_div_ready", div_ready, 0);
    chk("reset_sum_out", sum_out, 0);
    chk("reset_fifo_full", fifo_full, 0);
    chk("reset_err", err, 0);

    // 1: row sum 8*128
    do_acc(fill(20'd128));
    chk("acc_sum_out", sum_out, 1024);
    chk("acc_div_ready", div_ready, 1);
    pop_ext();
    chk("ext_pop_empty", sum_out, 0);
    chk("int_still_ready", div_ready, 1);

    // 2: d = 8 + 8 = 16, 640/16 = 40
    do_div(fill(20'd640), 24'd1024, 1'b0, fill(20'd40), 1'b0, 1'b1);
    chk("no_err_yet", err, 0);

    // 3: signed lane 0, then acc+div on the same edge, then the landed sum
    do_acc(fill(20'd128));
    do_acc(fill(20'd128));
    r3 = fill(20'd640);  r3[0] = 20'hFFD80;            // -640
    e3a = fill(20'd40);  e3a[0] = 20'hFFFD8;           // -40
    do_div(r3, 24'd1024, 1'b1, e3a, 1'b0, 1'b0);
    do_div(r3, 24'd1024, 1'b0, fill(20'd40), 1'b1, 1'b0);
    // head now 5120 (8*640), sum_in 0 -> d = 40, 640/40 = 16
    do_div(fill(20'd640), 24'd0, 1'b0, fill(20'd16), 1'b0, 1'b0);
    chk("int_empty_ready", div_ready, 0);
    chk("ext_head0", sum_out, 1024); pop_ext();
    chk("ext_head1", sum_out, 1024); pop_ext();
    chk("ext_head2", sum_out, 5120); pop_ext();
    chk("ext_drained", sum_out, 0);

    // 4: head 100, sum_in 27 -> d forced to 1
    r100 = '0; r100[0] = 20'd100;
    do_acc(r100);
    do_acc(r100);
    r4  = '0;
    r4[0] = 20'hFFFFB; r4[1] = 20'h80000; r4[2] = 20'd5;  r4[3] = 20'h7FFFF;
    r4[4] = 20'd0;     r4[5] = 20'hFFFFF; r4[6] = 20'd7;  r4[7] = 20'd7;
    e4a = r4; e4a[1] = 20'h80001;                      // -(2^19-1) after clamp
    e4b = '0;
    e4b[0] = 20'd5;    e4b[1] = 20'h80000; e4b[2] = 20'd5; e4b[3] = 20'h7FFFF;
    e4b[4] = 20'd0;    e4b[5] = 20'd1;     e4b[6] = 20'd7; e4b[7] = 20'd7;
    do_div(r4, 24'd27, 1'b1, e4a, 1'b0, 1'b0);
    do_div(r4, 24'd27, 1'b0, e4b, 1'b0, 1'b0);
    chk("err_clean_before_5", err, 0);

    // div with empty internal FIFO
    do_reset();
    sfp_in_r = fill(20'd640); div = 1'b1;
    tick();
    div = 1'b0;
    chk("div_empty_err", err, 1);
    chk("div_empty_ready", div_ready, 0);
    bad = 0;
    repeat (25) begin tick(); if (out_valid !== 1'b0) bad++; end
    chk("div_empty_no_output", bad, 0);

    // 5: fill, overflow, drain in order, then one div frees one slot
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("not_full_at_15", fifo_full, 0);
      do_acc(fill(BW'(k + 1)));
    end
    chk("full_at_16", fifo_full, 1);
    chk("no_err_at_16", err, 0);
    do_acc(fill(20'd99));
    chk("overflow_err", err, 1);
    chk("overflow_full", fifo_full, 1);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (sum_out !== SUM_BW'(8 * (k + 1))) bad++;
      pop_ext();
    end
    chk("ext_order_16", bad, 0);
    chk("ext_empty_after_16", sum_out, 0);
    // head 8 -> 0 after shift; d = 0 + 8 = 8, 40/8 = 5
    do_div(fill(20'd40), 24'd1024, 1'b0, fill(20'd5), 1'b0, 1'b0);
    chk("freed_slot", fifo_full, 0);
    do_acc(fill(20'd1));
    chk("refull", fifo_full, 1);

    // 6: reset during the divide
    sfp_in_r = fill(20'd640); sum_in = 24'd1024; sign_mode = 1'b0; div = 1'b1;
    tick();
    div = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_row("abort_sfp_out", sfp_out, '0);
    chk("abort_div_ready", div_ready, 0);
    chk("abort_fifo_full", fifo_full, 0);
    chk("abort_sum_out", sum_out, 0);
    chk("abort_err", err, 0);
    bad = 0;
    repeat (30) begin tick(); if (out_valid !== 1'b0) bad++; end
    chk("abort_no_output", bad, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
